// File: rtl/writeback_stage.sv
// Writeback stage: load extraction, 32x64 register file, retire counter; 1-cycle COMMIT after each transfer.
// Latency: result visible on wb_* one edge after transfer; array updated on the edge ending COMMIT.
// Backpressure: mem_ready low during COMMIT. Optional WB_BYPASS_EN forwards wb_data to read ports during COMMIT.
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [63:0] loaded_data,
    input  logic [63:0] alu_data,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic [4:0]  dest_reg,
    input  logic [1:0]  load_size,
    input  logic        load_unsigned,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [63:0] wb_data,
    output logic [63:0] retired_count
);

    typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

    state_t      state_q;
    logic        wb_valid_q;
    logic [4:0]  wb_dest_q;
    logic [63:0] wb_data_q;
    logic        wb_rw_q;
    logic [63:0] retired_q;
    logic [63:0] regs_q [32];

    logic [63:0] shifted;
    logic [63:0] load_ext;
    logic [63:0] wb_data_d;
    logic        sgn;

    // Misaligned loads deliberately keep the zero-filled upper bytes.
    always_comb begin
        shifted  = loaded_data >> {alu_data[2:0], 3'b000};
        sgn      = 1'b0;
        load_ext = shifted;
        case (load_size)
            2'd0: begin
                sgn      = ~load_unsigned & shifted[7];
                load_ext = {{56{sgn}}, shifted[7:0]};
            end
            2'd1: begin
                sgn      = ~load_unsigned & shifted[15];
                load_ext = {{48{sgn}}, shifted[15:0]};
            end
            2'd2: begin
                sgn      = ~load_unsigned & shifted[31];
                load_ext = {{32{sgn}}, shifted[31:0]};
            end
            default: load_ext = shifted;
        endcase
        wb_data_d = mem_to_reg ? load_ext : alu_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= 5'd0;
            wb_data_q  <= 64'd0;
            wb_rw_q    <= 1'b0;
            retired_q  <= 64'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_valid) begin
                        state_q    <= COMMIT;
                        wb_valid_q <= 1'b1;
                        wb_dest_q  <= dest_reg;
                        wb_data_q  <= wb_data_d;
                        wb_rw_q    <= reg_write;
                    end
                end
                COMMIT: begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    retired_q  <= retired_q + 64'd1;
                    if (wb_rw_q && (wb_dest_q != 5'd0)) regs_q[wb_dest_q] <= wb_data_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    logic byp_ok;
    assign byp_ok = (state_q == COMMIT) && wb_rw_q && (wb_dest_q != 5'd0);
`endif

    always_comb begin
        rs1_data = (rs1_addr == 5'd0) ? 64'd0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == 5'd0) ? 64'd0 : regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
        if (byp_ok && (rs1_addr == wb_dest_q)) rs1_data = wb_data_q;
        if (byp_ok && (rs2_addr == wb_dest_q)) rs2_data = wb_data_q;
`endif
    end

    assign mem_ready     = (state_q == IDLE);
    assign wb_valid      = wb_valid_q;
    assign wb_dest       = wb_dest_q;
    assign wb_data       = wb_data_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a scoreboard of expected commits.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [63:0] loaded_data = '0;
    logic [63:0] alu_data = '0;
    logic        mem_to_reg = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  dest_reg = '0;
    logic [1:0]  load_size = '0;
    logic        load_unsigned = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [63:0] wb_data;
    logic [63:0] retired_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          c0 = 0;
    logic [63:0] exp_ret = '0;
    logic [63:0] byp_exp;
    logic [68:0] sb [$];

    writeback_stage dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .loaded_data(loaded_data), .alu_data(alu_data), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .dest_reg(dest_reg), .load_size(load_size),
        .load_unsigned(load_unsigned), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .retired_count(retired_count)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic mtr, input logic rw, input logic [4:0] d,
                         input logic [63:0] ld, input logic [63:0] alu,
                         input logic [1:0] sz, input logic uns, input logic [63:0] exp);
        mem_to_reg    = mtr;
        reg_write     = rw;
        dest_reg      = d;
        loaded_data   = ld;
        alu_data      = alu;
        load_size     = sz;
        load_unsigned = uns;
        mem_valid     = 1'b1;
        sb.push_back({d, exp});
    endtask

    // Waits (bounded) for a commit pulse and checks it against the scoreboard head.
    task automatic wait_commit(input string tag);
        logic [68:0] e;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_commit_seen"}, {63'd0, seen}, 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_dest"}, {59'd0, wb_dest}, {59'd0, e[68:64]});
            chk({tag, "_data"}, wb_data, e[63:0]);
            chk({tag, "_ready_low"}, {63'd0, mem_ready}, 64'd0);
            exp_ret = exp_ret + 64'd1;
        end
    endtask

    task automatic idle_check(input string tag, input logic [4:0] a, input logic [63:0] v);
        rs1_addr = a;
        @(negedge clk);
        chk({tag, "_valid_low"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, "_ready_high"}, {63'd0, mem_ready}, 64'd1);
        chk({tag, "_retired"}, retired_count, exp_ret);
        chk({tag, "_reg"}, rs1_data, v);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", {63'd0, mem_ready}, 64'd1);
        chk("rst_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_dest", {59'd0, wb_dest}, 64'd0);
        chk("rst_data", wb_data, 64'd0);
        chk("rst_retired", retired_count, 64'd0);

        // Sign-extended byte at offset 1
        issue(1'b1, 1'b1, 5'd5, 64'h0000_0000_0000_80FF, 64'h1001, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        wait_commit("lb");
        mem_valid = 1'b0;
        rs1_addr  = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        byp_exp = 64'hFFFF_FFFF_FFFF_FF80;
`else
        byp_exp = 64'd0;
`endif
        chk("lb_read_in_commit", rs1_data, byp_exp);
        idle_check("lb", 5'd5, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_data_held", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_dest_held", {59'd0, wb_dest}, 64'd5);

        issue(1'b1, 1'b1, 5'd6, 64'h8765_4321_DEAD_BEEF, 64'h2004, 2'd2, 1'b1, 64'h0000_0000_8765_4321);
        wait_commit("lwu");
        mem_valid = 1'b0;
        idle_check("lwu", 5'd6, 64'h0000_0000_8765_4321);

        issue(1'b1, 1'b1, 5'd8, 64'h8765_4321_DEAD_BEEF, 64'h2006, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8765);
        wait_commit("lh");
        mem_valid = 1'b0;
        idle_check("lh", 5'd8, 64'hFFFF_FFFF_FFFF_8765);

        // Misaligned word: upper bytes are zero fill, so no sign extension happens
        issue(1'b1, 1'b1, 5'd9, 64'h8765_4321_DEAD_BEEF, 64'h2006, 2'd2, 1'b0, 64'h0000_0000_0000_8765);
        wait_commit("lw_mis");
        mem_valid = 1'b0;
        idle_check("lw_mis", 5'd9, 64'h0000_0000_0000_8765);

        issue(1'b1, 1'b1, 5'd15, 64'h8765_4321_DEAD_BEEF, 64'h2007, 2'd3, 1'b0, 64'h0000_0000_0000_0087);
        wait_commit("ld_mis");
        mem_valid = 1'b0;
        idle_check("ld_mis", 5'd15, 64'h0000_0000_0000_0087);

        issue(1'b1, 1'b1, 5'd10, 64'h8765_4321_DEAD_BEEF, 64'h3000, 2'd3, 1'b0, 64'h8765_4321_DEAD_BEEF);
        wait_commit("ld");
        mem_valid = 1'b0;
        idle_check("ld", 5'd10, 64'h8765_4321_DEAD_BEEF);

        // ALU result passes through untouched regardless of load_size/unsigned
        issue(1'b0, 1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_0000_0000_0081, 2'd0, 1'b0, 64'hDEAD_0000_0000_0081);
        wait_commit("alu");
        mem_valid = 1'b0;
        idle_check("alu", 5'd16, 64'hDEAD_0000_0000_0081);

        issue(1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2'd0, 1'b0, 64'h1234);
        wait_commit("x0");
        mem_valid = 1'b0;
        idle_check("x0", 5'd0, 64'd0);

        issue(1'b0, 1'b0, 5'd17, 64'd0, 64'h55, 2'd3, 1'b0, 64'h55);
        wait_commit("norw");
        mem_valid = 1'b0;
        idle_check("norw", 5'd17, 64'd0);

        // Back-to-back with mem_valid held high
        issue(1'b0, 1'b1, 5'd11, 64'd0, 64'h1111, 2'd0, 1'b0, 64'h1111);
        wait_commit("b2b0");
        c0 = cyc;
        issue(1'b0, 1'b1, 5'd12, 64'd0, 64'h2222, 2'd0, 1'b0, 64'h2222);
        @(negedge clk);
        chk("b2b_ready_1", {63'd0, mem_ready}, 64'd1);
        chk("b2b_valid_1", {63'd0, wb_valid}, 64'd0);
        wait_commit("b2b1");
        chk("b2b_gap_1", 64'(cyc - c0), 64'd2);
        c0 = cyc;
        issue(1'b0, 1'b1, 5'd13, 64'd0, 64'h3333, 2'd0, 1'b0, 64'h3333);
        @(negedge clk);
        chk("b2b_ready_2", {63'd0, mem_ready}, 64'd1);
        wait_commit("b2b2");
        chk("b2b_gap_2", 64'(cyc - c0), 64'd2);
        mem_valid = 1'b0;
        idle_check("b2b_x13", 5'd13, 64'h3333);
        idle_check("b2b_x11", 5'd11, 64'h1111);

        // Reset landing on the commit edge
        issue(1'b0, 1'b1, 5'd14, 64'd0, 64'h77, 2'd0, 1'b0, 64'h77);
        wait_commit("rstc");
        reset     = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = 64'd0;
        rs1_addr = 5'd14;
        rs2_addr = 5'd5;
        #1;
        chk("rstc_x14", rs1_data, 64'd0);
        chk("rstc_x5_cleared", rs2_data, 64'd0);
        chk("rstc_retired", retired_count, 64'd0);
        chk("rstc_valid", {63'd0, wb_valid}, 64'd0);
        chk("rstc_data", wb_data, 64'd0);
        chk("rstc_ready", {63'd0, mem_ready}, 64'd1);

        issue(1'b0, 1'b1, 5'd7, 64'd0, 64'hABCD, 2'd0, 1'b0, 64'hABCD);
        wait_commit("byp");
        mem_valid = 1'b0;
        rs1_addr  = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        byp_exp = 64'hABCD;
`else
        byp_exp = 64'd0;
`endif
        chk("byp_rs1", rs1_data, byp_exp);
        idle_check("byp_after", 5'd7, 64'hABCD);

        // No forwarding when the committing instruction does not write
        issue(1'b0, 1'b0, 5'd7, 64'd0, 64'h9999, 2'd0, 1'b0, 64'h9999);
        wait_commit("nobyp");
        mem_valid = 1'b0;
        rs2_addr  = 5'd7;
        #1;
        chk("nobyp_rs2", rs2_data, 64'hABCD);
        idle_check("nobyp_after", 5'd7, 64'hABCD);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
